operand_stage: RTL and testbench
================================

# operand_stage

Phase sequencer and register-access stage for the 5-phase (F/R/X/M/W) multicycle core. It latches the fetched instruction, drives the read ports of the 8 x 32-bit register file during R and captures the operands into `sr`/`tr`. It drives the write port during W with the result returned by the M stage. It also generates the one-hot phase vector consumed by the PC, ALU and memory stages, and counts retired instructions.

## Interface
- `N`, 32, data width of operands, result and instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- `ir_in`  in  32  instruction word from memory; sampled at end of F.
- `mem_wait`  in  1  hold phase M while high.
- `wb_en`  in  1  current instruction writes back; sampled during W.
- `result`  in  N  write-back data from the M stage.
- `rd1`, `rd2`  in  N  register-file read data.
- `phase`  out  5  one-hot phase: bit0=F, bit1=R, bit2=X, bit3=M, bit4=W; all zero in IDLE.
- `busy`  out  1  high in any phase other than IDLE.
- `ir`  out  32  latched instruction.
- `ra1`, `ra2`  out  3  register-file read addresses: `ir[23:21]` and `ir[20:18]`.
- `wa`  out  3  register-file write address: `ir[26:24]`.
- `wd`  out  N  register-file write data; equals `result`.
- `we`  out  1  register-file write enable.
- `sr`, `tr`  out  N  latched source operands.
- `icount`  out  N  retired-instruction count.

## Operation
- States: IDLE, F, R, X, M, W. `phase` is registered and one-hot, with no combinational path from inputs to `phase`.
- IDLE to F when `start`=1. Otherwise the block stays in IDLE.
- F to R, R to X, and X to M unconditionally.
- M stays in M while `mem_wait`=1, then moves to W.
- W moves to F, except when `ir[31:27]`=5'b11111 (HALT), in which case it moves to IDLE.
- `start` is ignored outside IDLE.
- End of F: `ir` <= `ir_in`.
- `ra1`, `ra2` and `wa` are combinational slices of `ir`, valid in every phase.
- End of R:
  - `sr` <= 0 if `ra1`==0, else `rd1`.
  - `tr` <= 0 if `ra2`==0, else `rd2`.
  - This gives r0 a read-as-zero property.
- `sr` and `tr` hold their value until the next R.
- `we` = `phase[4]` & `wb_en` & (`wa`!=0). It is combinational, so writes to r0 are suppressed.
- `wd` = `result`, passed through combinationally.
- End of W: `icount` <= `icount`+1. The count wraps modulo 2^N, and the HALT instruction is counted.
- Reset, async and asserted in any state:
  - `phase` is forced to 0, so the block is in IDLE.
  - `busy`, `ir`, `sr`, `tr` and `icount` are 0; `we` drops to 0 immediately.
  - An in-flight write is discarded. The register-file contents are not cleared.

## Timing
- Reset values: `phase`=0, `busy`=0, `ir`=0, `sr`=0, `tr`=0, `icount`=0, `we`=0.
- Reset values of the derived outputs: `ra1`=`ra2`=`wa`=0 and `wd`=`result`.
- `start` sampled at edge k puts the block in F for cycle k+1. R, X, M and W follow in cycles k+2 to k+5 when `mem_wait`=0.
- Minimum 5 cycles per instruction, plus one cycle per cycle `mem_wait` is high in M.
- A register written in W (edge at end of W) is visible to the next instruction's R, which comes 2 cycles later. No forwarding is needed.
- Read data must be stable during R. The register file reads asynchronously.
- `busy` is high exactly while `phase`!=0.

## Test plan
1. Reset, then `start`=1 for 1 cycle with `ir_in`=ADD r3,r1,r2 (`ir[26:24]`=3, `ir[23:21]`=1, `ir[20:18]`=2), `rd1`=5, `rd2`=7, `result`=12, `wb_en`=1, `mem_wait`=0 -> required response:
   - `phase` sequence 00001, 00010, 00100, 01000, 10000, 00001.
   - `sr`=5 and `tr`=7 after R.
   - `we`=1, `wa`=3 and `wd`=12 only during W.
   - `icount`=1.
2. Reads of r0 (`ir[23:21]`=0, `ir[20:18]`=0) with `rd1`=`rd2`=32'hFFFFFFFF -> `sr`=0, `tr`=0.
   - Write to `wa`=0 with `wb_en`=1 -> `we` stays 0.
3. Hold `mem_wait`=1 for 3 cycles in M -> `phase`=01000 for 4 cycles, then W. `sr` and `tr` are unchanged throughout.
4. HALT (`ir_in[31:27]`=5'b11111) -> after W, `phase`=0, `busy`=0 and `icount` incremented.
   - `start` pulsed during a running instruction has no effect.
   - `start` pulsed in IDLE restarts at F.
5. Assert `rst` mid-W with `we`=1 -> `we` falls in the same cycle with no clock edge, `phase`=0 and `icount`=0. After release, the block stays in IDLE until `start`.
6. Preload `icount` to 2^N-1 by running instructions (or use a reduced N) -> the next retire wraps `icount` to 0.

Source files
------------

// File: rtl/operand_stage_if.sv
// Operand-stage bus: fetch/control inputs, register-file ports, phase outputs.
// Latency: pure wiring, no state.
// Backpressure: mem_wait travels here and stretches the M phase of the stage.
interface operand_stage_if #(
  parameter int N = 32
);
  // Control and data arriving from the rest of the core
  logic         start;
  logic [31:0]  ir_in;
  logic         mem_wait;
  logic         wb_en;
  logic [N-1:0] result;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;

  // Sequencing state and register-file port signals produced by the stage
  logic [4:0]   phase;
  logic         busy;
  logic [31:0]  ir;
  logic [2:0]   ra1;
  logic [2:0]   ra2;
  logic [2:0]   wa;
  logic [N-1:0] wd;
  logic         we;
  logic [N-1:0] sr;
  logic [N-1:0] tr;
  logic [N-1:0] icount;

  // The operand stage itself
  modport master (
    input  start, ir_in, mem_wait, wb_en, result, rd1, rd2,
    output phase, busy, ir, ra1, ra2, wa, wd, we, sr, tr, icount
  );

  // The surrounding core: memory, register file, PC/ALU/memory stages
  modport slave (
    output start, ir_in, mem_wait, wb_en, result, rd1, rd2,
    input  phase, busy, ir, ra1, ra2, wa, wd, we, sr, tr, icount
  );
endinterface

// File: rtl/operand_stage.sv
// F/R/X/M/W phase sequencer with instruction latch, operand capture and write-back port.
// Latency: 5 cycles per instruction from F to the W edge; start in IDLE gives F next cycle.
// Backpressure: mem_wait high holds the sequencer in M; start is ignored while busy.
module operand_stage #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  operand_stage_if.master bus
);

  // The state encoding is the one-hot phase vector itself, so phase comes
  // straight from a flop with no decode logic behind it.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_F    = 5'b00001,
    S_R    = 5'b00010,
    S_X    = 5'b00100,
    S_M    = 5'b01000,
    S_W    = 5'b10000
  } state_t;

  localparam logic [4:0] HALT_OP = 5'b11111;

  state_t       state_q;
  state_t       state_d;
  logic [31:0]  ir_q;
  logic [N-1:0] sr_q;
  logic [N-1:0] tr_q;
  logic [N-1:0] icount_q;
  logic [2:0]   ra1;
  logic [2:0]   ra2;
  logic [2:0]   wa;
  logic         is_halt;

  // Register-file addresses are fixed fields of the latched instruction
  assign ra1     = ir_q[23:21];
  assign ra2     = ir_q[20:18];
  assign wa      = ir_q[26:24];
  assign is_halt = (ir_q[31:27] == HALT_OP);

  // Phase register; reset drops the block into IDLE from any phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase: fixed F->R->X->M walk, M stretched by mem_wait, HALT parks in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_F;
        end
      end
      S_F: state_d = S_R;
      S_R: state_d = S_X;
      S_X: state_d = S_M;
      S_M: begin
        if (!bus.mem_wait) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (is_halt) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_F;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction latch loads the fetched word at the end of F
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
    end else if (state_q == S_F) begin
      ir_q <= bus.ir_in;
    end
  end

  // Operand capture at the end of R; r0 always reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
      tr_q <= '0;
    end else if (state_q == S_R) begin
      sr_q <= (ra1 == 3'd0) ? '0 : bus.rd1;
      tr_q <= (ra2 == 3'd0) ? '0 : bus.rd2;
    end
  end

  // Retire counter bumps at the end of every W, HALT included; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount_q <= '0;
    end else if (state_q == S_W) begin
      icount_q <= icount_q + 1'b1;
    end
  end

  assign bus.phase  = state_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.ir     = ir_q;
  assign bus.ra1    = ra1;
  assign bus.ra2    = ra2;
  assign bus.wa     = wa;
  assign bus.sr     = sr_q;
  assign bus.tr     = tr_q;
  assign bus.icount = icount_q;
  assign bus.wd     = bus.result;
  // Write enable follows the phase flop directly, so reset kills it without a clock
  assign bus.we     = state_q[4] & bus.wb_en & (wa != 3'd0);

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: instruction-level reference schedule plus directed literal pins.
// Latency: expectations are built per instruction (F,R,X,M*(1+waits),W) and checked every cycle.
// Backpressure: mem_wait stretches M by a per-instruction wait count chosen by the bench.
module tb_operand_stage;

  logic clk;
  logic rst;

  operand_stage_if #(.N(32)) bus ();
  operand_stage_if #(.N(4))  b4 ();

  operand_stage #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  operand_stage #(.N(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));

  // Narrow instance sees the same control stream and the low data bits
  assign b4.start    = bus.start;
  assign b4.ir_in    = bus.ir_in;
  assign b4.mem_wait = bus.mem_wait;
  assign b4.wb_en    = bus.wb_en;
  assign b4.result   = bus.result[3:0];
  assign b4.rd1      = bus.rd1[3:0];
  assign b4.rd2      = bus.rd2[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miss    = 0;

  // Reference state at instruction level
  logic [31:0] m_ir, m_sr, m_tr, m_icount;
  // Expected outputs for the current cycle
  logic [4:0]  exp_phase;
  logic [31:0] exp_ir, exp_sr, exp_tr, exp_ic;
  logic        exp_we;
  logic        chk_en = 1'b0;

  logic        pin_w = 1'b0;
  logic        pin_we;
  logic [31:0] pin_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process against the schedule's expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase",   {27'd0, bus.phase}, {27'd0, exp_phase});
      chk("busy",    {31'd0, bus.busy}, {31'd0, (exp_phase != 5'd0)});
      chk("ir",      bus.ir, exp_ir);
      chk("ra1",     {29'd0, bus.ra1}, {29'd0, exp_ir[23:21]});
      chk("ra2",     {29'd0, bus.ra2}, {29'd0, exp_ir[20:18]});
      chk("wa",      {29'd0, bus.wa}, {29'd0, exp_ir[26:24]});
      chk("sr",      bus.sr, exp_sr);
      chk("tr",      bus.tr, exp_tr);
      chk("icount",  bus.icount, exp_ic);
      chk("we",      {31'd0, bus.we}, {31'd0, exp_we});
      chk("wd",      bus.wd, bus.result);
      chk("n4_phase", {27'd0, b4.phase}, {27'd0, exp_phase});
      chk("n4_sr",   {28'd0, b4.sr}, {28'd0, exp_sr[3:0]});
      chk("n4_icount", {28'd0, b4.icount}, {28'd0, exp_ic[3:0]});
      chk("n4_we",   {31'd0, b4.we}, {31'd0, exp_we});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic rand_inputs(input bit allow_start);
    bus.start    = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.ir_in    = $urandom;
    bus.rd1      = $urandom;
    bus.rd2      = $urandom;
    bus.result   = $urandom;
    bus.wb_en    = 1'($urandom_range(0, 1));
    bus.mem_wait = 1'($urandom_range(0, 1));
  endtask

  // Publish expectations for this cycle, then advance past the next edge
  task automatic tick(input logic [4:0] ph);
    exp_phase = ph;
    exp_ir    = m_ir;
    exp_sr    = m_sr;
    exp_tr    = m_tr;
    exp_ic    = m_icount;
    exp_we    = ph[4] & bus.wb_en & (m_ir[26:24] != 3'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ir = 0; m_sr = 0; m_tr = 0; m_icount = 0;
  endtask

  task automatic start_from_idle(input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) begin
      rand_inputs(1'b0);
      tick(5'b00000);
    end
    rand_inputs(1'b0);
    bus.start = 1'b1;
    tick(5'b00000);
  endtask

  // One instruction, entered with the DUT in F
  task automatic do_instr(input logic [31:0] ir, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] res, input bit wb, input int waits, input bit rst_w);
    rand_inputs(1'b1);
    bus.ir_in = ir;
    tick(5'b00001);
    m_ir = ir;
    rand_inputs(1'b1);
    bus.rd1 = r1;
    bus.rd2 = r2;
    tick(5'b00010);
    m_sr = (ir[23:21] == 3'd0) ? 32'd0 : r1;
    m_tr = (ir[20:18] == 3'd0) ? 32'd0 : r2;
    rand_inputs(1'b1);
    tick(5'b00100);
    for (int i = 0; i <= waits; i++) begin
      rand_inputs(1'b1);
      bus.mem_wait = (i < waits);
      tick(5'b01000);
    end
    rand_inputs(1'b1);
    bus.wb_en  = wb;
    bus.result = res;
    if (rst_w) begin
      #1;
      chk("we_before_rst", {31'd0, bus.we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_we",     {31'd0, bus.we}, 32'd0);
      chk("rst_phase",  {27'd0, bus.phase}, 32'd0);
      chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
      chk("rst_icount", bus.icount, 32'd0);
      chk_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      return;
    end
    if (pin_w) begin
      #1;
      chk("pin_we", {31'd0, bus.we}, {31'd0, pin_we});
      chk("pin_wd", bus.wd, pin_wd);
    end
    tick(5'b10000);
    m_icount = m_icount + 1;
  endtask

  function automatic logic [31:0] rand_ir(input bit halt);
    logic [31:0] v;
    v = $urandom;
    if (halt) v[31:27] = 5'b11111;
    else if (v[31:27] == 5'b11111) v[31] = 1'b0;
    return v;
  endfunction

  initial begin
    model_reset();
    rst = 1'b1;
    rand_inputs(1'b0);
    bus.result = 32'h0000_1234;
    #3;
    chk("reset_phase",  {27'd0, bus.phase}, 32'd0);
    chk("reset_busy",   {31'd0, bus.busy}, 32'd0);
    chk("reset_ir",     bus.ir, 32'd0);
    chk("reset_sr",     bus.sr, 32'd0);
    chk("reset_tr",     bus.tr, 32'd0);
    chk("reset_icount", bus.icount, 32'd0);
    chk("reset_we",     {31'd0, bus.we}, 32'd0);
    chk("reset_addr",   {23'd0, bus.ra1, bus.ra2, bus.wa}, 32'd0);
    chk("reset_wd",     bus.wd, 32'h0000_1234);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // ADD r3,r1,r2
    start_from_idle(2);
    pin_w = 1'b1; pin_we = 1'b1; pin_wd = 32'd12;
    do_instr(32'h0328_0000, 32'd5, 32'd7, 32'd12, 1'b1, 0, 1'b0);
    pin_w = 1'b0;
    chk("add_sr", bus.sr, 32'd5);
    chk("add_tr", bus.tr, 32'd7);
    chk("add_icount", bus.icount, 32'd1);
    chk("add_next_f", {27'd0, bus.phase}, 32'd1);

    // r0 reads and suppressed write to r0
    pin_w = 1'b1; pin_we = 1'b0; pin_wd = 32'hABCD_0001;
    do_instr(32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hABCD_0001, 1'b1, 0, 1'b0);
    pin_w = 1'b0;
    chk("r0_sr", bus.sr, 32'd0);
    chk("r0_tr", bus.tr, 32'd0);

    // Three wait cycles in M
    do_instr(32'h0124_0000, 32'h1111_2222, 32'h3333_4444, 32'd9, 1'b1, 3, 1'b0);
    chk("wait_sr", bus.sr, 32'h1111_2222);
    chk("wait_tr", bus.tr, 32'h3333_4444);

    // HALT parks in IDLE, then restart
    do_instr(32'hF900_0000, 32'd1, 32'd2, 32'd3, 1'b0, 1, 1'b0);
    chk("halt_phase",  {27'd0, bus.phase}, 32'd0);
    chk("halt_busy",   {31'd0, bus.busy}, 32'd0);
    chk("halt_icount", bus.icount, 32'd4);
    start_from_idle(3);

    // Reset in the middle of a writing W
    do_instr(32'h0528_0000, 32'd4, 32'd6, 32'd77, 1'b1, 0, 1'b1);
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs(1'b0);
      tick(5'b00000);
    end
    start_from_idle(1);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++)
      do_instr(rand_ir(1'b0), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'b0);
    chk("n4_icount_15", {28'd0, b4.icount}, 32'd15);
    do_instr(rand_ir(1'b0), $urandom, $urandom, $urandom, 1'b1, 0, 1'b0);
    chk("n4_icount_wrap", {28'd0, b4.icount}, 32'd0);
    chk("icount_16", bus.icount, 32'd16);

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      logic        halt;
      logic [31:0] ir;
      halt = ($urandom_range(0, 7) == 0);
      ir   = rand_ir(halt);
      do_instr(ir, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'b0);
      if (halt) start_from_idle($urandom_range(0, 3));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
